input_ram_seq: RTL

- Read sequencer for the dual-word input RAM (two words per pair index, one-cycle registered read).
- On a start pulse, walks the pair index from 0 to the last pair and presents each pair to a downstream consumer with a valid/ready handshake.
- Stream is back-to-back: one pair per cycle when the consumer is ready.
- Also issues the RAM's reload (rst) pulse, so the RAM is never reloaded mid-stream.

---
 rtl/input_ram_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/input_ram_seq.sv
// Read sequencer for the dual-word input RAM: streams pairs 0..LAST with valid/ready
// and owns the RAM reload strobe. Optional macro INPUT_RAM_SEQ_LEN_EN adds a runtime length.
module input_ram_seq #(
  parameter  int R  = 16,
  localparam int IW = $clog2(R) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          reload,
  input  logic          pair_ready,
`ifdef INPUT_RAM_SEQ_LEN_EN
  input  logic [IW:0]   len,
`endif
  output logic [IW-1:0] i,
  output logic          ram_rst,
  output logic          pair_valid,
  output logic [IW-1:0] pair_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {S_IDLE, S_RELOAD, S_PRIME, S_STREAM, S_DONE} state_t;

  localparam logic [IW-1:0] LAST_FULL = IW'(R/2 - 1);

  state_t        r_state, w_next;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] w_last;
  logic          w_hs;
  logic          w_go;
  logic          w_at_last;

`ifdef INPUT_RAM_SEQ_LEN_EN
  logic [IW-1:0] r_last;
  logic [IW:0]   w_len_c;
  // Lengths beyond the RAM's pair count are clamped rather than wrapped.
  assign w_len_c = (len > (IW+1)'(R/2)) ? (IW+1)'(R/2) : len;
  assign w_last  = r_last;
`else
  assign w_last  = LAST_FULL;
`endif

  assign w_go      = (r_state == S_IDLE) && !reload && start;
  assign w_hs      = (r_state == S_STREAM) && pair_ready;
  assign w_at_last = (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
`ifdef INPUT_RAM_SEQ_LEN_EN
      r_last  <= LAST_FULL;
`endif
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt  <= '0;
`ifdef INPUT_RAM_SEQ_LEN_EN
        r_last <= IW'(w_len_c - (IW+1)'(1));
`endif
      end else if (w_hs) begin
        r_cnt <= w_at_last ? '0 : r_cnt + IW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (reload)     w_next = S_RELOAD;
        else if (start) begin
`ifdef INPUT_RAM_SEQ_LEN_EN
          w_next = (len == '0) ? S_DONE : S_PRIME;
`else
          w_next = S_PRIME;
`endif
        end
      end
      S_RELOAD: w_next = S_IDLE;
      S_PRIME:  w_next = S_STREAM;
      S_STREAM: if (w_hs && w_at_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Address runs one pair ahead while the consumer accepts, so the registered
  // RAM read lands exactly when the next pair is presented.
  always_comb begin
    i          = '0;
    pair_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_PRIME:  busy = 1'b1;
      S_STREAM: begin
        busy       = 1'b1;
        pair_valid = 1'b1;
        i          = (pair_ready && !w_at_last) ? r_cnt + IW'(1) : r_cnt;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  assign pair_idx = r_cnt;
  assign ram_rst  = rst | (r_state == S_RELOAD);

endmodule
